// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
package fifo_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   // Width of the per-requester beat statistics counters.
   localparam int STAT_W = 16;

   // Beat counter must represent 0..burst_len.
   function automatic int beat_cnt_w(input int burst_len);
      return $clog2(burst_len + 1);
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: the first asserted request searching upward from
// last_i+1, wrapping modulo NUM_REQ. Purely combinational.
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   last_i,
   output logic [NUM_REQ-1:0] pick_oh_o,
   output logic [IDX_W-1:0]   pick_idx_o,
   output logic               any_valid_o
);

   logic             found;
   logic [IDX_W-1:0] cand;

   // Scan candidates in priority order and keep the first hit.
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
      pick_oh_o  = '0;
      pick_idx_o = '0;
      found      = 1'b0;
      cand       = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = IDX_W'((int'(last_i) + i) % NUM_REQ);
         if (!found && req_i[cand]) begin
            found            = 1'b1;
            pick_oh_o[cand]  = 1'b1;
            pick_idx_o       = cand;
         end
      end
   end

   assign any_valid_o = |req_i;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing the single write port of synch_fifo.
// Optional macro FIFO_WR_ARB_STATS_EN adds per-requester accepted-beat
// counters on beat_count_o.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int BURST_LEN  = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
   output logic [NUM_REQ-1:0]            req_ready_o,
   input  logic                          fifo_full_i,
   output logic                          fifo_wr_en_o,
   output logic [DATA_WIDTH-1:0]         fifo_wdata_o,
   output logic [NUM_REQ-1:0]            grant_o,
   output logic                          busy_o
`ifdef FIFO_WR_ARB_STATS_EN
   ,
   output logic [NUM_REQ*STAT_W-1:0]     beat_count_o
`endif
);

   localparam int                IDX_W     = $clog2(NUM_REQ);
   localparam int                BCW       = beat_cnt_w(BURST_LEN);
   localparam logic [BCW-1:0]    LAST_BEAT = BCW'(BURST_LEN - 1);
   localparam logic [IDX_W-1:0]  LAST_RST  = IDX_W'(NUM_REQ - 1);

   arb_state_e          state_q, state_d;
   logic [NUM_REQ-1:0]  grant_q, grant_d;
   logic [IDX_W-1:0]    last_q, last_d;
   logic [BCW-1:0]      beat_q, beat_d;

   logic [NUM_REQ-1:0]  accept;
   logic [NUM_REQ-1:0]  pick_oh;
   logic [IDX_W-1:0]    pick_idx;
   logic                any_valid;
   logic                granted_valid;
   logic                burst_done;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req_i       (req_valid_i),
      .last_i      (last_q),
      .pick_oh_o   (pick_oh),
      .pick_idx_o  (pick_idx),
      .any_valid_o (any_valid)
   );

   // Zero-latency write datapath; a full FIFO withdraws ready.
   assign req_ready_o   = grant_q & {NUM_REQ{~fifo_full_i}};
   assign accept        = req_valid_i & req_ready_o;
   assign fifo_wr_en_o  = |accept;
   assign grant_o       = grant_q;
   assign busy_o        = (state_q == GRANT);
   assign granted_valid = |(grant_q & req_valid_i);
   assign burst_done    = fifo_wr_en_o && (beat_q == LAST_BEAT);

   // Forward the accepted requester's data; grant is one-hot so at most one hits.
   always_comb begin
      fifo_wdata_o = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (accept[k]) fifo_wdata_o = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // Next-state: grant from IDLE, count beats, release and re-arbitrate in GRANT.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      beat_d  = beat_q;
      case (state_q)
         IDLE: begin
            if (any_valid) begin
               grant_d = pick_oh;
               last_d  = pick_idx;
               beat_d  = '0;
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (burst_done || !granted_valid) begin
               beat_d = '0;
               if (any_valid) begin
                  grant_d = pick_oh;
                  last_d  = pick_idx;
               end else begin
                  grant_d = '0;
                  state_d = IDLE;
               end
            end else if (fifo_wr_en_o) begin
               beat_d = beat_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Arbiter state registers; last_q resets so requester 0 wins first.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         last_q  <= LAST_RST;
         beat_q  <= '0;
      end else begin
         // NOTE: state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         beat_q  <= beat_d;
      end
   end

`ifdef FIFO_WR_ARB_STATS_EN
   logic [STAT_W-1:0] stat_q [NUM_REQ];

   // Saturating per-requester accepted-beat counters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < NUM_REQ; k++) stat_q[k] <= '0;
      end else begin
         for (int k = 0; k < NUM_REQ; k++) begin
            if (accept[k] && (stat_q[k] != {STAT_W{1'b1}})) stat_q[k] <= stat_q[k] + 1'b1;
         end
      end
   end

   // Flatten the counters onto the output bus.
   always_comb begin
      beat_count_o = '0;
      for (int k = 0; k < NUM_REQ; k++) beat_count_o[k*STAT_W +: STAT_W] = stat_q[k];
   end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: vector table, directed corner
// sequences and randomized traffic against a behavioural model.
module tb_fifo_wr_arbiter;

   localparam int NR = 4;
   localparam int DW = 8;
   localparam int BL = 4;
   localparam int FIFO_DEPTH = 16;

   logic              clk;
   logic              rst;
   logic [NR-1:0]     req_valid_i;
   logic [NR*DW-1:0]  req_data_i;
   logic [NR-1:0]     req_ready_o;
   logic              fifo_full_i;
   logic              fifo_wr_en_o;
   logic [DW-1:0]     fifo_wdata_o;
   logic [NR-1:0]     grant_o;
   logic              busy_o;
`ifdef FIFO_WR_ARB_STATS_EN
   logic [NR*16-1:0]  beat_count_o;
`endif

   fifo_wr_arbiter #(
      .NUM_REQ    (NR),
      .DATA_WIDTH (DW),
      .BURST_LEN  (BL)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid_i  (req_valid_i),
      .req_data_i   (req_data_i),
      .req_ready_o  (req_ready_o),
      .fifo_full_i  (fifo_full_i),
      .fifo_wr_en_o (fifo_wr_en_o),
      .fifo_wdata_o (fifo_wdata_o),
      .grant_o      (grant_o),
      .busy_o       (busy_o)
`ifdef FIFO_WR_ARB_STATS_EN
      ,
      .beat_count_o (beat_count_o)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   int m_gnt;          // granted requester, -1 when idle
   int m_beats;        // beats accepted in the current grant
   int m_last;         // most recently granted requester
   int m_cnt [NR];     // accepted beats per requester since reset
   logic [DW-1:0] wlog[$];   // every FIFO write observed this test
   logic [DW-1:0] fq[$];     // bench FIFO contents
   bit use_fifo;
   bit ovf;

   task automatic m_reset();
      m_gnt   = -1;
      m_beats = 0;
      m_last  = NR - 1;
      for (int k = 0; k < NR; k++) m_cnt[k] = 0;
   endtask

   function automatic int m_pick(input logic [NR-1:0] v);
      int c;
      for (int i = 1; i <= NR; i++) begin
         c = (m_last + i) % NR;
         if (v[c]) return c;
      end
      return -1;
   endfunction

   // Check one cycle's outputs against the model, then step across the edge.
   task automatic cycle();
      logic [NR-1:0] eg;
      logic [NR-1:0] er;
      logic          ew;
      logic [DW-1:0] ed;
      int            p;
      bit            rel;
      #1;
      eg = (m_gnt < 0) ? '0 : NR'(1 << m_gnt);
      er = fifo_full_i ? '0 : eg;
      ew = (m_gnt >= 0) && !fifo_full_i && req_valid_i[m_gnt];
      ed = ew ? req_data_i[m_gnt*DW +: DW] : '0;
      check("grant", grant_o, eg);
      check("ready", req_ready_o, er);
      check("wr_en", fifo_wr_en_o, ew);
      check("wdata", fifo_wdata_o, ed);
      check("busy", busy_o, m_gnt >= 0);
      if (fifo_full_i && fifo_wr_en_o) ovf = 1'b1;
      if (ew) begin
         wlog.push_back(ed);
         m_cnt[m_gnt]++;
         if (use_fifo) fq.push_back(ed);
      end
      if (m_gnt < 0) begin
         p = m_pick(req_valid_i);
         if (p >= 0) begin
            m_gnt = p; m_last = p; m_beats = 0;
         end
      end else begin
         rel = 1'b0;
         if (ew) begin
            m_beats++;
            if (m_beats == BL) rel = 1'b1;
         end
         if (!req_valid_i[m_gnt]) rel = 1'b1;
         if (rel) begin
            p = m_pick(req_valid_i);
            m_gnt = p;
            if (p >= 0) m_last = p;
            m_beats = 0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero(input string tag);
      #1;
      check({tag, "_ready"}, req_ready_o, '0);
      check({tag, "_wr_en"}, fifo_wr_en_o, 1'b0);
      check({tag, "_wdata"}, fifo_wdata_o, '0);
      check({tag, "_grant"}, grant_o, '0);
      check({tag, "_busy"}, busy_o, 1'b0);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      req_valid_i = '0;
      fifo_full_i = 1'b0;
      use_fifo = 1'b0;
      ovf = 1'b0;
      fq.delete();
      wlog.delete();
      m_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [NR-1:0] valid;
      logic          full;
      logic [NR-1:0] grant;
      logic [NR-1:0] ready;
      logic          wr;
      logic [DW-1:0] wdata;
      logic          busy;
   } vec_t;

   vec_t tbl [12];

   initial begin
      // Early release of requester 2, stall while full, release on valid drop while full.
      tbl[0]  = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0};
      tbl[1]  = '{4'b0100, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0};
      tbl[2]  = '{4'b0100, 1'b0, 4'b0100, 4'b0100, 1'b1, 8'hA2, 1'b1};
      tbl[3]  = '{4'b0100, 1'b1, 4'b0100, 4'b0000, 1'b0, 8'h00, 1'b1};
      tbl[4]  = '{4'b0100, 1'b0, 4'b0100, 4'b0100, 1'b1, 8'hA2, 1'b1};
      tbl[5]  = '{4'b0000, 1'b0, 4'b0100, 4'b0100, 1'b0, 8'h00, 1'b1};
      tbl[6]  = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0};
      tbl[7]  = '{4'b1001, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0};
      tbl[8]  = '{4'b1001, 1'b0, 4'b1000, 4'b1000, 1'b1, 8'hA3, 1'b1};
      tbl[9]  = '{4'b1001, 1'b1, 4'b1000, 4'b0000, 1'b0, 8'h00, 1'b1};
      tbl[10] = '{4'b0001, 1'b1, 4'b1000, 4'b0000, 1'b0, 8'h00, 1'b1};
      tbl[11] = '{4'b0001, 1'b0, 4'b0001, 4'b0001, 1'b1, 8'hA0, 1'b1};

      rst = 1'b0;
      req_valid_i = '0;
      req_data_i = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      fifo_full_i = 1'b0;
      use_fifo = 1'b0;
      ovf = 1'b0;
      m_reset();
      @(posedge clk);
      #1;

      // Reset held with all requesters valid: everything stays quiet.
      req_valid_i = '1;
      repeat (3) begin
         check_zero("rst_hold");
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      m_reset();
      cycle();                 // arbitration cycle, nothing granted yet
      cycle();                 // requester 0 granted
      check("rst_release_first_grant", wlog.size(), 1);

      // Vector table.
      do_reset();
      req_data_i = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      for (int i = 0; i < 12; i++) begin
         req_valid_i = tbl[i].valid;
         fifo_full_i = tbl[i].full;
         #1;
         check($sformatf("tbl%0d_grant", i), grant_o, tbl[i].grant);
         check($sformatf("tbl%0d_ready", i), req_ready_o, tbl[i].ready);
         check($sformatf("tbl%0d_wr_en", i), fifo_wr_en_o, tbl[i].wr);
         check($sformatf("tbl%0d_wdata", i), fifo_wdata_o, tbl[i].wdata);
         check($sformatf("tbl%0d_busy", i), busy_o, tbl[i].busy);
         @(posedge clk);
         #1;
      end

      // Fairness: all valid, 40 beats, bursts of BL in order 0,1,2,3,...
      do_reset();
      req_valid_i = '1;
      cycle();
      for (int c = 0; c < 40; c++) cycle();
      check("fair_write_count", wlog.size(), 40);
      for (int b = 0; b < 40 && b < wlog.size(); b++)
         check($sformatf("fair_beat%0d_src", b), wlog[b], 8'hA0 + 8'((b / BL) % NR));
`ifdef FIFO_WR_ARB_STATS_EN
      for (int k = 0; k < NR; k++)
         check($sformatf("stats_fair_req%0d", k), beat_count_o[k*16 +: 16], 16'd10);
`endif

      // Backpressure: requester 0 streams 20 beats into a 16-deep FIFO with no reads.
      do_reset();
      use_fifo = 1'b1;
      for (int c = 0; c < 30; c++) begin
         req_valid_i = (m_cnt[0] < 20) ? 4'b0001 : 4'b0000;
         fifo_full_i = (fq.size() >= FIFO_DEPTH);
         cycle();
      end
      check("bp_writes_until_full", wlog.size(), 16);
      for (int c = 0; c < 14; c++) begin
         req_valid_i = (m_cnt[0] < 20) ? 4'b0001 : 4'b0000;
         fifo_full_i = (fq.size() >= FIFO_DEPTH);
         cycle();
         if (c < 4 && fq.size() > 0) void'(fq.pop_front());
      end
      check("bp_writes_after_reads", wlog.size(), 20);
      check("bp_fifo_level", fq.size(), 16);
      check("bp_no_overflow", ovf, 1'b0);
      use_fifo = 1'b0;

      // Reset mid-burst: asynchronous clear, then requester 0 wins first.
      do_reset();
      req_valid_i = 4'b1110;
      cycle();
      cycle();
      cycle();
      check("midrst_beats_before", wlog.size(), 2);
      #2;
      rst = 1'b0;
      check_zero("midrst_async");
      @(posedge clk);
      #1;
      rst = 1'b1;
      m_reset();
      req_valid_i = '1;
      cycle();
      #1;
      check("midrst_prio_req0", grant_o, 4'b0001);
      @(posedge clk);
      #1;
      do_reset();

      // Randomized traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         req_valid_i = 4'($urandom);
         req_data_i  = $urandom;
         fifo_full_i = ($urandom_range(0, 3) == 0);
         cycle();
      end
`ifdef FIFO_WR_ARB_STATS_EN
      for (int k = 0; k < NR; k++)
         check($sformatf("stats_rand_req%0d", k), beat_count_o[k*16 +: 16], 16'(m_cnt[k]));
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin, burst-granting arbiter that shares the single write port of synch_fifo among NUM_REQ producers.
- Each producer uses a valid/ready handshake.
- The arbiter drives the FIFO's wr_en_i/wdata_i and obeys its full_o, so the FIFO's overflow_o can never assert.
- Sits directly in front of synch_fifo in the producer path.

Parameters:
- NUM_REQ, 4, number of requesters (≥2).
- DATA_WIDTH, 8, data width; matches the FIFO's DATA_WIDTH.
- BURST_LEN, 4, maximum accepted beats per grant before forced re-arbitration (≥1).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- req_valid_i  input  NUM_REQ  per-requester data valid.
- req_data_i  input  NUM_REQ*DATA_WIDTH  packed data; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- req_ready_o  output  NUM_REQ  per-requester ready; a beat transfers when valid&ready at posedge.
- fifo_full_i  input  1  from the FIFO's full_o.
- fifo_wr_en_o  output  1  to the FIFO's wr_en_i.
- fifo_wdata_o  output  DATA_WIDTH  to the FIFO's wdata_i.
- grant_o  output  NUM_REQ  registered one-hot current grant; 0 when idle.
- busy_o  output  1  1 when the FSM is in GRANT.

Behaviour:
- Reset (rst=0, async): state=IDLE, grant_q=0, beat_cnt=0, last_q=NUM_REQ-1 (requester 0 wins first). Outputs: req_ready_o=0, fifo_wr_en_o=0, fifo_wdata_o=0, grant_o=0, busy_o=0.
- Combinational datapath, zero latency:
  - req_ready_o[k] = grant_q[k] & ~fifo_full_i.
  - fifo_wr_en_o = |(req_valid_i & req_ready_o).
  - fifo_wdata_o = data of the granted requester when fifo_wr_en_o=1, else 0.
- Round-robin pick: first asserted req_valid_i bit searching upward from last_q+1, wrapping modulo NUM_REQ.
- IDLE:
  - If any req_valid_i, at the next posedge: grant_q=one-hot(pick), last_q=pick, beat_cnt=0, state→GRANT.
  - Grant takes effect the cycle after the request, i.e. a one-cycle arbitration latency from IDLE.
- GRANT:
  - Each accepted beat increments beat_cnt.
  - Release occurs at a posedge where either:
    - a beat is accepted with beat_cnt==BURST_LEN-1, or
    - the granted requester's req_valid_i=0.
  - On release, re-arbitrate in the same edge, excluding nothing. The pointer has advanced, so the releasing requester has the lowest priority.
    - If any valid: new grant, beat_cnt=0, stay in GRANT.
    - Else: grant_q=0, state→IDLE.
- Full: fifo_full_i=1 stalls the burst. ready=0, beat_cnt holds, grant holds, with no timeout. Releasing on valid drop still applies while full.
- Simultaneous FIFO read/write is the FIFO's concern; the arbiter only looks at full.
- Width rules: beat_cnt width is $clog2(BURST_LEN+1); last_q width is $clog2(NUM_REQ).
- Reset mid-burst clears all state immediately. A partially sent burst is abandoned; no beat is duplicated or dropped at the FIFO boundary, because transfers are single-cycle.
- Requesters must hold data stable while valid&!ready; the arbiter does not check this.

Optional Feature:
- Macro: FIFO_WR_ARB_STATS_EN.
- Defined: adds output beat_count_o (NUM_REQ*16 bits), one 16-bit counter per requester.
  - Increments on each accepted beat of that requester.
  - Saturates at 16'hFFFF.
  - Cleared by reset.
- Undefined: the port and counters are absent; all other behaviour is identical.

Decomposition:
- Package fifo_arb_pkg holds:
  - the state enum {IDLE, GRANT};
  - the BEAT_CNT_W derivation function;
  - the counter width constant STAT_W=16.
- One sub-module, rr_pick: purely combinational. Inputs are the request vector and last_q; outputs are the one-hot pick, its index, and any_valid.

Test Plan:
1. Reset: hold rst=0 with all valids=1 → req_ready_o=0, fifo_wr_en_o=0, grant_o=0. Release rst → grant_o=4'b0001 one cycle later.
2. Fairness: all 4 requesters valid continuously, BURST_LEN=4, FIFO never full → FIFO receives 4 beats from each in order 0,1,2,3,0; grant changes with no idle cycle.
3. Early release: requester 2 alone sends 2 beats, then drops valid → 2 FIFO writes, busy_o falls the next cycle, beat_cnt resets.
4. Backpressure: DEPTH=16 FIFO with no reads, requester 0 streaming 20 beats → exactly 16 writes; ready=0 while full; FIFO overflow_o stays 0. Reading 4 entries then resumes exactly 4 more writes.
5. Reset mid-burst: assert rst after 2 of 4 beats → outputs are 0 asynchronously within the same cycle; after release, requester 0 has priority.
6. FIFO_WR_ARB_STATS_EN defined, scenario 2 run for 40 beats → beat_count_o = 10 per requester.
